// File: rtl/iir_sched_pkg.sv
// Shared constants and types for the IIR coefficient scheduler.
// Holds config addresses, field widths, FSM states and the bank layout.
package iir_sched_pkg;

    localparam int CX_W  = 40;
    localparam int CXS_W = 8;
    localparam int CY_W  = 24;

    localparam logic [2:0] ADDR_CX   = 3'd0;
    localparam logic [2:0] ADDR_CX0  = 3'd1;
    localparam logic [2:0] ADDR_CX1  = 3'd2;
    localparam logic [2:0] ADDR_CX2  = 3'd3;
    localparam logic [2:0] ADDR_CY0  = 3'd4;
    localparam logic [2:0] ADDR_CY1  = 3'd5;
    localparam logic [2:0] ADDR_CY2  = 3'd6;
    localparam logic [2:0] ADDR_RSVD = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        APPLY
    } state_t;

    typedef struct packed {
        logic [CX_W-1:0]  cx;
        logic [CXS_W-1:0] cx0;
        logic [CXS_W-1:0] cx1;
        logic [CXS_W-1:0] cx2;
        logic [CY_W-1:0]  cy0;
        logic [CY_W-1:0]  cy1;
        logic [CY_W-1:0]  cy2;
    } coef_t;

endpackage

// File: rtl/iir_ce_gen.sv
// Fractional-rate strobe generator: ce at (STEREO+1)*SAMPLE_RATE, sample_ce after each R ce.
// Ports: clk, reset (sync, active-high), en; outputs ce, sample_ce.
module iir_ce_gen #(
    parameter int unsigned CLK_RATE    = 24576000,
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned STEREO      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic ce,
    output logic sample_ce
);

    localparam logic [31:0] INC  = 32'(SAMPLE_RATE * (STEREO + 1));
    localparam logic [31:0] WRAP = 32'(CLK_RATE);

    logic [31:0] acc;
    logic [31:0] sum;
    logic        wrap;
    logic        phase;
    logic        phase_eff;
    logic        sample_q;

    assign sum  = acc + INC;
    assign wrap = (sum >= WRAP);

    // Mono streams have no L/R split: every ce closes a frame.
    assign phase_eff = (STEREO != 0) ? phase : 1'b1;

    assign ce        = en & ~reset & wrap;
    assign sample_ce = en & ~reset & sample_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            phase    <= 1'b0;
            sample_q <= 1'b0;
        end else if (!en) begin
            // Accumulator holds; the next frame restarts on L.
            phase    <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            acc      <= wrap ? (sum - WRAP) : sum;
            sample_q <= wrap & phase_eff;
            if (wrap) begin
                phase <= ~phase;
            end
        end
    end

endmodule

// File: rtl/iir_coeff_sched.sv
// IIR coefficient sequencer: shadow/active banks swapped on a frame boundary, plus strobes.
// Ports: clk, reset, en, cfg_we/addr/data/commit in; busy, commit_done, cfg_err, ce,
// sample_ce, filt_reset, cx, cx0..cx2, cy0..cy2 out. IIR_COEFF_SCHED_FLUSH_EN enables filt_reset.
module iir_coeff_sched
    import iir_sched_pkg::*;
#(
    parameter int unsigned CLK_RATE    = 24576000,
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned STEREO      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [39:0] cfg_data,
    input  logic        cfg_commit,
    output logic        busy,
    output logic        commit_done,
    output logic        cfg_err,
    output logic        ce,
    output logic        sample_ce,
    output logic        filt_reset,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2
);

    state_t state;
    state_t state_nx;
    coef_t  shadow;
    coef_t  active;
    logic   idle;

    iir_ce_gen #(
        .CLK_RATE    (CLK_RATE),
        .SAMPLE_RATE (SAMPLE_RATE),
        .STEREO      (STEREO)
    ) u_ce_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .ce        (ce),
        .sample_ce (sample_ce)
    );

    assign idle = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            shadow <= '0;
            active <= '0;
        end else begin
            state <= state_nx;
            if (idle && cfg_we) begin
                case (cfg_addr)
                    ADDR_CX:  shadow.cx  <= cfg_data[CX_W-1:0];
                    ADDR_CX0: shadow.cx0 <= cfg_data[CXS_W-1:0];
                    ADDR_CX1: shadow.cx1 <= cfg_data[CXS_W-1:0];
                    ADDR_CX2: shadow.cx2 <= cfg_data[CXS_W-1:0];
                    ADDR_CY0: shadow.cy0 <= cfg_data[CY_W-1:0];
                    ADDR_CY1: shadow.cy1 <= cfg_data[CY_W-1:0];
                    ADDR_CY2: shadow.cy2 <= cfg_data[CY_W-1:0];
                    default:  ;
                endcase
            end
            if (state == APPLY) begin
                active <= shadow;
            end
        end
    end

    // Stopped strobes mean no frame is in flight, so apply at once.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (cfg_commit) state_nx = PENDING;
            PENDING: if (sample_ce || !en) state_nx = APPLY;
            APPLY:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy        = (state == PENDING);
    assign commit_done = (state == APPLY);
    assign cfg_err     = cfg_we & ~idle & ~reset;

`ifdef IIR_COEFF_SCHED_FLUSH_EN
    assign filt_reset = (state == APPLY);
`else
    assign filt_reset = 1'b0;
`endif

    assign cx  = active.cx;
    assign cx0 = active.cx0;
    assign cx1 = active.cx1;
    assign cx2 = active.cx2;
    assign cy0 = active.cy0;
    assign cy1 = active.cy1;
    assign cy2 = active.cy2;

endmodule
